// File: rtl/memory_arbiter_if.sv
// Bundle of the instruction-side, data-side and main-memory signals that
// pass through the memory arbiter. The arbiter takes the slave view; the
// caches and memory model together form the master view.
interface memory_arbiter_if;
  logic [31:0] iAddress;
  logic        iReadEnable;
  logic [31:0] iDataOut;
  logic        iReady;

  logic [31:0] dAddress;
  logic        dReadEnable;
  logic        dWriteEnable;
  logic [31:0] dDataIn;
  logic [31:0] dDataOut;
  logic        dReady;

  logic [31:0] memoryAddress;
  logic [31:0] memoryDataOut;
  logic        memoryReadEnable;
  logic        memoryWriteEnable;
  logic [31:0] memoryDataIn;
  logic        memoryReady;

  logic        timeoutError;

  modport slave (
    input  iAddress, iReadEnable,
    input  dAddress, dReadEnable, dWriteEnable, dDataIn,
    input  memoryDataIn, memoryReady,
    output iDataOut, iReady,
    output dDataOut, dReady,
    output memoryAddress, memoryDataOut, memoryReadEnable, memoryWriteEnable,
    output timeoutError
  );

  modport master (
    output iAddress, iReadEnable,
    output dAddress, dReadEnable, dWriteEnable, dDataIn,
    output memoryDataIn, memoryReady,
    input  iDataOut, iReady,
    input  dDataOut, dReady,
    input  memoryAddress, memoryDataOut, memoryReadEnable, memoryWriteEnable,
    input  timeoutError
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one main-memory port between the instruction and data caches.
// One requester is served at a time, ties alternate round-robin, the grant
// is held until memory answers or the per-transaction timeout expires, and
// every transaction ends with a one-cycle DONE state that emits the ready
// pulse and lets the requester drop its request before the next grant.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  memory_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Last wait count at which a serve state may still be waiting for memory.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        last_grant;   // 0 = instruction side, 1 = data side
  logic [7:0]  wait_count;
  logic [31:0] i_data;
  logic [31:0] d_data;
  logic        i_ready;
  logic        d_ready;
  logic        timeout_error;

  logic        i_req;
  logic        d_req;
  logic        grant_d;
  logic        serve_abort;
  logic        serve_end;
  logic [31:0] serve_result;

  assign i_req = bus.iReadEnable;
  assign d_req = bus.dReadEnable | bus.dWriteEnable;

  // Data side wins when alone, or on a tie when the instruction side was last served.
  assign grant_d = d_req & (~i_req | ~last_grant);

  // Memory answering takes priority over an abort in the same cycle.
  assign serve_abort  = ~bus.memoryReady & (wait_count == LAST_WAIT);
  assign serve_end    = bus.memoryReady | serve_abort;
  assign serve_result = bus.memoryReady ? bus.memoryDataIn : 32'hFFFF_FFFF;

  // Arbitration state machine with completion/abort bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b0;
      wait_count    <= 8'd0;
      i_data        <= 32'd0;
      d_data        <= 32'd0;
      i_ready       <= 1'b0;
      d_ready       <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state      <= grant_d ? SERVE_D : SERVE_I;
            last_grant <= grant_d;
            wait_count <= 8'd0;
          end
        end
        SERVE_I: begin
          if (serve_end) begin
            i_data        <= serve_result;
            i_ready       <= 1'b1;
            timeout_error <= serve_abort;
            state         <= DONE;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        SERVE_D: begin
          if (serve_end) begin
            d_data        <= serve_result;
            d_ready       <= 1'b1;
            timeout_error <= serve_abort;
            state         <= DONE;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        default: begin
          // DONE: pulses end here; no grant so the requester can drop its request.
          i_ready       <= 1'b0;
          d_ready       <= 1'b0;
          timeout_error <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Memory port is a pure function of the state and the live requester inputs.
  always_comb begin
    bus.memoryAddress     = 32'd0;
    bus.memoryDataOut     = 32'd0;
    bus.memoryReadEnable  = 1'b0;
    bus.memoryWriteEnable = 1'b0;
    case (state)
      SERVE_I: begin
        bus.memoryAddress    = bus.iAddress;
        bus.memoryReadEnable = 1'b1;
      end
      SERVE_D: begin
        bus.memoryAddress     = bus.dAddress;
        bus.memoryDataOut     = bus.dDataIn;
        bus.memoryWriteEnable = bus.dWriteEnable;
        bus.memoryReadEnable  = bus.dReadEnable & ~bus.dWriteEnable;
      end
      default: ;
    endcase
  end

  assign bus.iDataOut     = i_data;
  assign bus.iReady       = i_ready;
  assign bus.dDataOut     = d_data;
  assign bus.dReady       = d_ready;
  assign bus.timeoutError = timeout_error;

endmodule
